// File: rtl/psram_qspi_responder.sv
`default_nettype none
// ============================================================================
// Module : psram_qspi_responder
// Quad-SPI PSRAM device emulator: 0xEB quad read, 0x38 quad write, sampled
// on clk_i. Optional macro PSRAM_RESP_QPI_CMD_EN adds a QPI command phase.
// Rev    : 1.0
// ============================================================================
module psram_qspi_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DUMMY = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic [3:0] douten
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_cmd    = 3'd1;
  localparam logic [2:0] c_st_addr   = 3'd2;
  localparam logic [2:0] c_st_dummy  = 3'd3;
  localparam logic [2:0] c_st_rdata  = 3'd4;
  localparam logic [2:0] c_st_wdata  = 3'd5;
  localparam logic [2:0] c_st_ignore = 3'd6;

  localparam logic [4:0] c_dummy_last = 5'(DUMMY - 1);

  logic       r_sck_s1, r_sck_s2, r_sck_s3;
  logic       r_cen_s1, r_cen_s2, r_cen_s3;
  logic [3:0] r_din_s1, r_din_s2;

  logic [2:0]    r_state;
  logic [4:0]    r_cnt;
  logic [6:0]    r_cmd;
  logic [AW-1:0] r_addr;
  logic          r_rd;
  logic          r_nib;
  logic [3:0]    r_whi;
  logic [3:0]    r_dout;
  logic [3:0]    r_douten;
  logic [7:0]    r_mem [DEPTH];

  logic          w_rise, w_fall, w_cen, w_cen_fall, w_we, w_cmd_last;
  logic [3:0]    w_din;
  logic [7:0]    w_cmd_next;
  logic [7:0]    w_rd_byte;
  logic [AW-1:0] w_addr_inc;

  // ce_n synchronisers reset to "selected" so a transfer already in flight
  // at reset release never looks like a fresh ce_n fall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_s3 <= 1'b0;
      r_cen_s1 <= 1'b0;
      r_cen_s2 <= 1'b0;
      r_cen_s3 <= 1'b0;
      r_din_s1 <= 4'h0;
      r_din_s2 <= 4'h0;
    end else begin
      r_sck_s1 <= sck;
      r_sck_s2 <= r_sck_s1;
      r_sck_s3 <= r_sck_s2;
      r_cen_s1 <= ce_n;
      r_cen_s2 <= r_cen_s1;
      r_cen_s3 <= r_cen_s2;
      r_din_s1 <= din;
      r_din_s2 <= r_din_s1;
    end
  end

  assign w_rise     = r_sck_s2 & ~r_sck_s3;
  assign w_fall     = ~r_sck_s2 & r_sck_s3;
  assign w_cen      = r_cen_s2;
  assign w_cen_fall = ~r_cen_s2 & r_cen_s3;
  assign w_din      = r_din_s2;
  assign w_rd_byte  = r_mem[r_addr];
  assign w_addr_inc = r_addr + AW'(1);
  assign w_we       = (r_state == c_st_wdata) & w_rise & r_nib & ~w_cen;

`ifdef PSRAM_RESP_QPI_CMD_EN
  logic r_qpi;
  assign w_cmd_next = r_qpi ? {r_cmd[3:0], w_din} : {r_cmd, w_din[0]};
  assign w_cmd_last = r_qpi ? (r_cnt == 5'd1) : (r_cnt == 5'd7);
`else
  assign w_cmd_next = {r_cmd, w_din[0]};
  assign w_cmd_last = (r_cnt == 5'd7);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= c_st_idle;
      r_cnt    <= 5'd0;
      r_cmd    <= 7'd0;
      r_addr   <= '0;
      r_rd     <= 1'b0;
      r_nib    <= 1'b0;
      r_whi    <= 4'h0;
      r_dout   <= 4'h0;
      r_douten <= 4'h0;
`ifdef PSRAM_RESP_QPI_CMD_EN
      r_qpi    <= 1'b0;
`endif
    end else if (w_cen) begin
      r_state  <= c_st_idle;
      r_cnt    <= 5'd0;
      r_cmd    <= 7'd0;
      r_nib    <= 1'b0;
      r_dout   <= 4'h0;
      r_douten <= 4'h0;
    end else begin
      case (r_state)
        c_st_idle: begin
          // An sck rise landing with the ce_n fall is the first command bit.
          if (w_cen_fall) begin
            r_state <= c_st_cmd;
            r_cnt   <= w_rise ? 5'd1 : 5'd0;
            r_cmd   <= w_rise ? w_cmd_next[6:0] : 7'd0;
          end
        end
        c_st_cmd: begin
          if (w_rise) begin
            r_cmd <= w_cmd_next[6:0];
            r_cnt <= r_cnt + 5'd1;
            if (w_cmd_last) begin
              r_cnt <= 5'd0;
              case (w_cmd_next)
                8'hEB: begin
                  r_rd    <= 1'b1;
                  r_state <= c_st_addr;
                end
                8'h38: begin
                  r_rd    <= 1'b0;
                  r_state <= c_st_addr;
                end
`ifdef PSRAM_RESP_QPI_CMD_EN
                8'h35: begin
                  r_qpi   <= 1'b1;
                  r_state <= c_st_ignore;
                end
                8'hF5: begin
                  r_qpi   <= 1'b0;
                  r_state <= c_st_ignore;
                end
`endif
                default: r_state <= c_st_ignore;
              endcase
            end
          end
        end
        c_st_addr: begin
          if (w_rise) begin
            r_addr <= {r_addr[AW-5:0], w_din};
            r_cnt  <= r_cnt + 5'd1;
            if (r_cnt == 5'd5) begin
              r_cnt   <= 5'd0;
              r_nib   <= 1'b0;
              r_state <= r_rd ? ((DUMMY == 0) ? c_st_rdata : c_st_dummy) : c_st_wdata;
            end
          end
        end
        c_st_dummy: begin
          if (w_rise) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == c_dummy_last) begin
              r_cnt   <= 5'd0;
              r_state <= c_st_rdata;
            end
          end
        end
        c_st_rdata: begin
          if (w_fall) begin
            r_douten <= 4'hF;
            r_nib    <= ~r_nib;
            if (!r_nib) begin
              r_dout <= w_rd_byte[7:4];
            end else begin
              r_dout <= w_rd_byte[3:0];
              r_addr <= w_addr_inc;
            end
          end
        end
        c_st_wdata: begin
          if (w_rise) begin
            r_nib <= ~r_nib;
            if (!r_nib) begin
              r_whi <= w_din;
            end else begin
              r_addr <= w_addr_inc;
            end
          end
        end
        c_st_ignore: r_douten <= 4'h0;
        default:     r_state  <= c_st_idle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_we) begin
      r_mem[r_addr] <= {r_whi, w_din};
    end
  end

  assign dout   = r_dout;
  assign douten = r_douten;

endmodule
`default_nettype wire

// File: tb/tb_psram_qspi_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_psram_qspi_responder
// Table vectors, corner sequences and random bursts against a byte-array model.
// Rev    : 1.0
// ============================================================================
module tb_psram_qspi_responder;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DUMMY = 6;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       sck;
  logic       ce_n;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] douten;

  int total   = 0;
  int bad     = 0;
  int oe_hits = 0;

  logic [7:0] mm  [DEPTH];
  bit         vld [DEPTH];
  logic [23:0] wr_addrs[$];

  typedef struct {
    bit          wr;
    logic [23:0] a;
    int          n;
    logic [31:0] d;
  } vec_t;

  vec_t tbl [7];

  psram_qspi_responder #(.DEPTH(DEPTH), .AW(AW), .DUMMY(DUMMY)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .sck    (sck),
    .ce_n   (ce_n),
    .din    (din),
    .dout   (dout),
    .douten (douten)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (douten !== 4'h0) oe_hits++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic sck_cyc(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
    din = d;
    repeat (5) @(negedge clk);
    q  = dout;
    oe = douten;
    sck = 1'b1;
    repeat (5) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic cs_lo();
    @(negedge clk);
    ce_n = 1'b0;
  endtask

  task automatic cs_hi();
    repeat (3) @(negedge clk);
    ce_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    logic [3:0] q, oe;
    for (int i = 7; i >= 0; i--) sck_cyc({3'b000, c[i]}, q, oe);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [3:0] q, oe;
    for (int i = 5; i >= 0; i--) sck_cyc(a[4*i +: 4], q, oe);
  endtask

  task automatic wr_burst(input logic [23:0] a, input int n, input logic [31:0] d, input string nm);
    logic [3:0] q, oe;
    int h0;
    h0 = oe_hits;
    cs_lo();
    send_cmd(8'h38);
    send_addr(a);
    for (int i = 2*n-1; i >= 0; i--) sck_cyc(4'(d >> (4*i)), q, oe);
    cs_hi();
    for (int i = 0; i < n; i++) begin
      mm[(int'(a) + i) % DEPTH]  = 8'(d >> (8*(n-1-i)));
      vld[(int'(a) + i) % DEPTH] = 1'b1;
    end
    chk({nm, "_oe"}, 32'(oe_hits - h0), 32'd0);
  endtask

  task automatic rd_burst(input logic [23:0] a, input int n, output logic [31:0] got,
                          output int ob, output int pre);
    logic [3:0] q, oe;
    int h0;
    got = '0;
    ob  = 0;
    h0  = oe_hits;
    cs_lo();
    send_cmd(8'hEB);
    send_addr(a);
    for (int i = 0; i < DUMMY; i++) sck_cyc(4'($urandom), q, oe);
    pre = oe_hits - h0;
    for (int i = 0; i < 2*n; i++) begin
      sck_cyc(4'h0, q, oe);
      got = {got[27:0], q};
      if (oe !== 4'hF) ob++;
    end
    cs_hi();
  endtask

  task automatic rd_check(input logic [23:0] a, input int n, input logic [31:0] exp,
                          input logic [31:0] mask, input string nm);
    logic [31:0] got;
    int ob, pre;
    rd_burst(a, n, got, ob, pre);
    chk({nm, "_data"}, got & mask, exp & mask);
    chk({nm, "_oe_data"}, 32'(ob), 32'd0);
    chk({nm, "_oe_pre"}, 32'(pre), 32'd0);
  endtask

  initial begin
    logic [3:0]  q, oe;
    logic [23:0] a;
    logic [31:0] d, exp, mask;
    int          h0, n, idx;

    tbl[0] = '{wr: 1'b1, a: 24'h000010, n: 2, d: 32'h0000A53C};
    tbl[1] = '{wr: 1'b0, a: 24'h000010, n: 2, d: 32'h0000A53C};
    tbl[2] = '{wr: 1'b1, a: 24'h0003FF, n: 2, d: 32'h00001122};
    tbl[3] = '{wr: 1'b0, a: 24'h0003FF, n: 2, d: 32'h00001122};
    tbl[4] = '{wr: 1'b0, a: 24'h000000, n: 1, d: 32'h00000022};
    tbl[5] = '{wr: 1'b1, a: 24'h000021, n: 1, d: 32'h0000005A};
    tbl[6] = '{wr: 1'b0, a: 24'hFFF010, n: 2, d: 32'h0000A53C};

    rst_i = 1'b1;
    sck   = 1'b0;
    ce_n  = 1'b1;
    din   = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_dout", {28'd0, dout}, 32'd0);
    chk("reset_douten", {28'd0, douten}, 32'd0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].wr) wr_burst(tbl[i].a, tbl[i].n, tbl[i].d, $sformatf("tbl%0d_wr", i));
      else rd_check(tbl[i].a, tbl[i].n, tbl[i].d, 32'hFFFFFFFF, $sformatf("tbl%0d_rd", i));
    end

    // Aborted write: third nibble must be dropped, neighbour untouched.
    h0 = oe_hits;
    cs_lo();
    send_cmd(8'h38);
    send_addr(24'h000020);
    sck_cyc(4'h7, q, oe);
    sck_cyc(4'h7, q, oe);
    sck_cyc(4'h9, q, oe);
    cs_hi();
    chk("abort_wr_oe", 32'(oe_hits - h0), 32'd0);
    mm[32'h20] = 8'h77;
    vld[32'h20] = 1'b1;
    rd_check(24'h000020, 2, 32'h0000775A, 32'hFFFFFFFF, "abort_rd");

    // Read aborted by ce_n: outputs released three clocks after the pin rises.
    cs_lo();
    send_cmd(8'hEB);
    send_addr(24'h000010);
    for (int i = 0; i < DUMMY; i++) sck_cyc(4'h0, q, oe);
    sck_cyc(4'h0, q, oe);
    sck_cyc(4'h0, q, oe);
    repeat (4) @(negedge clk);
    chk("rdabort_oe_on", {28'd0, douten}, 32'h0000000F);
    ce_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rdabort_oe_off", {28'd0, douten}, 32'd0);
    repeat (6) @(negedge clk);

    // sck activity with ce_n high, then an unknown command with trailing clocks.
    h0 = oe_hits;
    for (int i = 0; i < 3; i++) sck_cyc(4'($urandom), q, oe);
    cs_lo();
    send_cmd(8'h9F);
    for (int i = 0; i < 16; i++) sck_cyc(4'($urandom), q, oe);
    cs_hi();
    chk("unk_oe", 32'(oe_hits - h0), 32'd0);
    rd_check(24'h000010, 2, 32'h0000A53C, 32'hFFFFFFFF, "unk_rd");
    rd_check(24'h0003FF, 2, 32'h00001122, 32'hFFFFFFFF, "unk_rd_wrap");

    // Reset during the second byte of a read.
    cs_lo();
    send_cmd(8'hEB);
    send_addr(24'h000010);
    for (int i = 0; i < DUMMY; i++) sck_cyc(4'h0, q, oe);
    for (int i = 0; i < 3; i++) sck_cyc(4'h0, q, oe);
    repeat (4) @(negedge clk);
    chk("rst_pre_dout", {28'd0, dout}, 32'h0000000C);
    chk("rst_pre_oe", {28'd0, douten}, 32'h0000000F);
    rst_i = 1'b1;
    #1;
    chk("rst_async_dout", {28'd0, dout}, 32'd0);
    chk("rst_async_oe", {28'd0, douten}, 32'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    // ce_n still low: a stale write without a fresh ce_n fall must be ignored.
    h0 = oe_hits;
    send_cmd(8'h38);
    send_addr(24'h000010);
    sck_cyc(4'hF, q, oe);
    sck_cyc(4'hF, q, oe);
    cs_hi();
    chk("rst_stale_oe", 32'(oe_hits - h0), 32'd0);
    rd_check(24'h000010, 2, 32'h0000A53C, 32'hFFFFFFFF, "rst_rd");

    // Random bursts against the byte-array model.
    for (int t = 0; t < 30; t++) begin
      if (wr_addrs.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = 24'($urandom);
        if ($urandom_range(0, 3) == 0) a[9:0] = 10'(DEPTH - 1 - $urandom_range(0, 2));
        n = $urandom_range(1, 4);
        d = $urandom;
        wr_burst(a, n, d, "rnd_wr");
        wr_addrs.push_back(a);
      end else begin
        a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
        n = $urandom_range(1, 4);
        exp  = '0;
        mask = '0;
        for (int i = 0; i < n; i++) begin
          idx  = (int'(a) + i) % DEPTH;
          exp  = {exp[23:0], mm[idx]};
          mask = {mask[23:0], vld[idx] ? 8'hFF : 8'h00};
        end
        rd_check(a, n, exp, mask, "rnd_rd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
